// File: rtl/proc_ctrl_fsm_if.sv
// Shared RAM port handshake between the control FSM and the memory.
// The master side requests accesses; the slave side answers with mem_ready.
interface proc_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM for the processor_1 RV32I datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and arbitrates the single RAM port.
module proc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    proc_ctrl_fsm_if.master   bus,
    input  logic              start,
    input  logic [6:0]        opcode,
    input  logic              branch_taken,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic              alu_src_b,
    output logic [1:0]        alu_op,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic [5:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR,
        C_BRANCH,
        C_LOAD,
        C_STORE,
        C_OPIMM,
        C_OP
    } cls_t;

    state_t            st;
    cls_t              cls;
    cls_t              dec_cls;
    logic              dec_sys;
    logic [WAIT_W-1:0] wait_cnt;

    assign state = {3'b000, st};

    // Classify the IR opcode; only consumed while in DECODE.
    always_comb begin
        dec_cls = C_NONE;
        dec_sys = 1'b0;
        case (opcode)
            OPC_LUI:    dec_cls = C_LUI;
            OPC_AUIPC:  dec_cls = C_AUIPC;
            OPC_JAL:    dec_cls = C_JAL;
            OPC_JALR:   dec_cls = C_JALR;
            OPC_BRANCH: dec_cls = C_BRANCH;
            OPC_LOAD:   dec_cls = C_LOAD;
            OPC_STORE:  dec_cls = C_STORE;
            OPC_OPIMM:  dec_cls = C_OPIMM;
            OPC_OP:     dec_cls = C_OP;
            OPC_SYSTEM: dec_sys = 1'b1;
            default:    dec_cls = C_NONE;
        endcase
    end

    // State, instruction class, RAM wait counter and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            cls       <= C_NONE;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            if (pc_we) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            case (st)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        st <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        st <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        st <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    cls      <= dec_cls;
                    wait_cnt <= '0;
                    if (dec_sys) begin
                        st <= S_HALT;
                    end else if (dec_cls == C_NONE) begin
                        st <= S_ERROR;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (cls == C_BRANCH) begin
                        st <= S_FETCH;
                    end else if (cls == C_LOAD || cls == C_STORE) begin
                        st <= S_MEM;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        st       <= (cls == C_LOAD) ? S_WB : S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        st <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    st       <= S_FETCH;
                end
                S_HALT:  st <= S_HALT;
                S_ERROR: st <= S_ERROR;
                default: st <= S_ERROR;
            endcase
        end
    end

    // Datapath controls decode from state (and mem_ready for the Mealy strobes)
    // so that an asynchronous reset drops every request immediately.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_src           = 2'd0;
        alu_src_a        = 1'b0;
        alu_src_b        = 1'b0;
        alu_op           = 2'd0;
        reg_we           = 1'b0;
        wb_sel           = 2'd0;
        halted           = 1'b0;
        illegal          = 1'b0;
        case (st)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                ir_we       = bus.mem_ready;
            end
            S_EXEC: begin
                case (cls)
                    C_OP: begin
                        alu_op = 2'd2;
                    end
                    C_OPIMM: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd2;
                    end
                    C_LUI, C_AUIPC, C_JAL: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    C_JALR, C_LOAD, C_STORE: begin
                        alu_src_b = 1'b1;
                    end
                    C_BRANCH: begin
                        alu_op = 2'd1;
                        pc_we  = 1'b1;
                        pc_src = branch_taken ? 2'd1 : 2'd0;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (cls == C_STORE);
                pc_we            = bus.mem_ready && (cls == C_STORE);
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                case (cls)
                    C_LOAD: wb_sel = 2'd1;
                    C_JAL: begin
                        wb_sel = 2'd2;
                        pc_src = 2'd1;
                    end
                    C_JALR: begin
                        wb_sel = 2'd2;
                        pc_src = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted  = 1'b1;
            S_ERROR: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
